mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mips_mem_pkg.sv | 42 ++++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// access-size encodings, FSM state type, latched request record,
// watchdog limit and the alignment check helper.
package mips_mem_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BE_W          = 4;
  localparam int unsigned TIMEOUT_LIMIT = 255;

  // MEM_size encodings; 2'b11 is treated as a word access
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Attributes of the in-flight access needed to finish a load
  typedef struct packed {
    logic       is_load;
    logic [1:0] size;
    logic [1:0] offset;
    logic       is_unsigned;
  } req_t;

  // Halfwords need an even address, words a multiple of four
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      default:   mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for sub-word accesses.
// Ports:
//   size, offset, is_unsigned - access size, addr[1:0], zero-extend flag
//   wdata, rdata              - raw store data / raw memory read word
//   be_c                      - little-endian byte enables
//   wdata_rep_c               - store data replicated across all lanes
//   load_data_c               - selected load lane, sign/zero extended
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_rep_c,
  output logic [DATA_W-1:0] load_data_c
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Byte enables, store replication and load extraction per access size
  always_comb begin
    be_c        = '1;
    wdata_rep_c = wdata;
    load_data_c = rdata;
    lane_byte   = 8'h00;
    lane_half   = 16'h0000;
    case (size)
      SIZE_BYTE: begin
        be_c        = BE_W'(1) << offset;
        wdata_rep_c = {4{wdata[7:0]}};
        case (offset)
          2'd0:    lane_byte = rdata[7:0];
          2'd1:    lane_byte = rdata[15:8];
          2'd2:    lane_byte = rdata[23:16];
          default: lane_byte = rdata[31:24];
        endcase
        load_data_c = {{24{lane_byte[7] & ~is_unsigned}}, lane_byte};
      end
      SIZE_HALF: begin
        be_c        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{wdata[15:0]}};
        lane_half   = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data_c = {{16{lane_half[15] & ~is_unsigned}}, lane_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller. Turns a load/store request into a
// single registered bus transaction, stalls the pipeline until the memory
// acknowledges, and returns aligned/extended load data.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to add an 8-bit watchdog
// that abandons an unacknowledged access after TIMEOUT_LIMIT cycles.
// Ports:
//   clk, nrst                    - clock, async active-low reset
//   MEM_rd_en / MEM_wr_en        - load / store request (store wins if both)
//   MEM_addr, MEM_wdata          - byte address, store data
//   MEM_size, MEM_unsigned       - access size, zero-extend loads
//   mem_req/we/addr/be/wdata     - registered memory bus, active in ACCESS
//   mem_rdata, mem_ack           - memory read data, one-cycle completion
//   MEM_dataout                  - last completed load result
//   stall                        - combinational pipeline freeze
//   misalign_err, timeout_err    - one-cycle error pulses
module mem_access_ctrl
  import mips_mem_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              MEM_rd_en,
  input  logic              MEM_wr_en,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_wdata,
  input  logic [1:0]        MEM_size,
  input  logic              MEM_unsigned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] MEM_dataout,
  output logic              stall,
  output logic              misalign_err,
  output logic              timeout_err
);

  state_t state;
  req_t   req_q;

  logic              op_valid;
  logic              misaligned;
  logic              start;
  logic              reject;
  logic              wd_expire;
  logic [1:0]        sel_size;
  logic [1:0]        sel_offset;
  logic              sel_unsigned;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_rep_c;
  logic [DATA_W-1:0] load_data_c;

  assign op_valid   = MEM_rd_en | MEM_wr_en;
  assign misaligned = is_misaligned(MEM_size, MEM_addr[1:0]);
  assign start      = (state == ST_IDLE) & op_valid & ~misaligned;
  assign reject     = (state == ST_IDLE) & op_valid &  misaligned;

  // Stall is held off during reset even if a request is presented
  assign stall = nrst & ((state == ST_ACCESS) | start);

  // Lane logic sees the live request in IDLE and the latched one afterwards
  assign sel_size     = (state == ST_IDLE) ? MEM_size      : req_q.size;
  assign sel_offset   = (state == ST_IDLE) ? MEM_addr[1:0] : req_q.offset;
  assign sel_unsigned = (state == ST_IDLE) ? MEM_unsigned  : req_q.is_unsigned;

  mem_lane_align u_lane_align (
    .size        (sel_size),
    .offset      (sel_offset),
    .is_unsigned (sel_unsigned),
    .wdata       (MEM_wdata),
    .rdata       (mem_rdata),
    .be_c        (be_c),
    .wdata_rep_c (wdata_rep_c),
    .load_data_c (load_data_c)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog counts unacknowledged ACCESS cycles; an ack always takes priority
  assign wd_expire = (wd_cnt == 8'(TIMEOUT_LIMIT - 1)) & ~mem_ack;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt <= 8'd0;
    end else if (start) begin
      wd_cnt <= 8'd0;
    end else if ((state == ST_ACCESS) && !mem_ack) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // One-cycle pulse aligned with the DONE cycle of an abandoned access
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == ST_ACCESS) & wd_expire;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Access FSM with registered bus outputs and load result
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      req_q        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      MEM_dataout  <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= MEM_wr_en;
            mem_addr  <= {MEM_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= MEM_wr_en ? wdata_rep_c : '0;
            req_q     <= '{is_load:     ~MEM_wr_en,
                           size:        MEM_size,
                           offset:      MEM_addr[1:0],
                           is_unsigned: MEM_unsigned};
          end else if (reject) begin
            misalign_err <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (mem_ack || wd_expire) begin
            state     <= ST_DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (req_q.is_load) begin
              MEM_dataout <= mem_ack ? load_data_c : '0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a table of load/store vectors
// driven through a scoreboard of expected bus transactions, plus hand
// sequences for reset, ignored acks/inputs and the long-wait behaviour.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        MEM_rd_en, MEM_wr_en;
  logic [31:0] MEM_addr, MEM_wdata;
  logic [1:0]  MEM_size;
  logic        MEM_unsigned;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] MEM_dataout;
  logic        stall, misalign_err, timeout_err;

  mem_access_ctrl dut (
    .clk          (clk),
    .nrst         (nrst),
    .MEM_rd_en    (MEM_rd_en),
    .MEM_wr_en    (MEM_wr_en),
    .MEM_addr     (MEM_addr),
    .MEM_wdata    (MEM_wdata),
    .MEM_size     (MEM_size),
    .MEM_unsigned (MEM_unsigned),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .MEM_dataout  (MEM_dataout),
    .stall        (stall),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          ack_delay;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  vec_t        vecs[14];
  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic uns, input logic [31:0] rdata, input int dly,
                              input logic mis, input logic [3:0] be,
                              input logic [31:0] mwdata, input logic [31:0] ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.rdata = rdata; v.ack_delay = dly; v.mis = mis; v.be = be; v.mwdata = mwdata; v.ld = ld;
    return v;
  endfunction

  task automatic idle_inputs();
    MEM_rd_en = 1'b0; MEM_wr_en = 1'b0;
  endtask

  // Drive one request for a single cycle and follow it to completion
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   stall_cnt;
    logic is_load;
    is_load = v.rd & ~v.wr;
    @(negedge clk);
    MEM_rd_en = v.rd; MEM_wr_en = v.wr; MEM_addr = v.addr; MEM_wdata = v.wdata;
    MEM_size = v.size; MEM_unsigned = v.uns;
    if (!v.mis) begin
      e.we = v.wr; e.addr = {v.addr[31:2], 2'b00}; e.be = v.be;
      e.wdata = v.wr ? v.mwdata : 32'h0;
      sb.push_back(e);
    end
    #1;
    chk($sformatf("v%0d stall_issue", idx), 32'(stall), 32'(!v.mis));
    stall_cnt = stall ? 1 : 0;
    @(posedge clk); #1;
    idle_inputs();
    if (v.mis) begin
      chk($sformatf("v%0d misalign_pulse", idx), 32'(misalign_err), 32'd1);
      chk($sformatf("v%0d mis_no_req", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d mis_stall", idx), 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d misalign_end", idx), 32'(misalign_err), 32'd0);
      chk($sformatf("v%0d mis_no_req2", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d mis_dataout", idx), MEM_dataout, model_dout);
    end else begin
      chk($sformatf("v%0d req", idx), 32'(mem_req), 32'd1);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL v%0d scoreboard_empty actual=0 required=1", idx);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d we", idx), 32'(mem_we), 32'(e.we));
        chk($sformatf("v%0d addr", idx), mem_addr, e.addr);
        chk($sformatf("v%0d be", idx), 32'(mem_be), 32'(e.be));
        chk($sformatf("v%0d wdata", idx), mem_wdata, e.wdata);
      end
      for (int d = 0; d < v.ack_delay; d++) begin
        if (stall) stall_cnt++;
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      #1;
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (is_load) model_dout = v.ld;
      chk($sformatf("v%0d done_stall", idx), 32'(stall), 32'd0);
      chk($sformatf("v%0d done_req", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.ack_delay + 2));
      chk($sformatf("v%0d dataout", idx), MEM_dataout, model_dout);
      @(posedge clk); #1;
      chk($sformatf("v%0d dataout_hold", idx), MEM_dataout, model_dout);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    //           rd    wr    addr          wdata         sz     uns   rdata         dly mis   be       mwdata        ld
    vecs[0]  = mk(1'b0, 1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 32'h0,        1, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b0, 32'h8001_1234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b1, 32'h8001_1234, 0, 1'b0, 4'b1100, 32'h0,        32'h0000_8001);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0000_3001, 32'h0,        2'b10, 1'b0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vecs[4]  = mk(1'b1, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h5555_5555, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0000_5001, 32'h0,        2'b00, 1'b0, 32'h1234_8056, 0, 1'b0, 4'b0010, 32'h0,        32'hFFFF_FF80);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0000_5003, 32'h0,        2'b00, 1'b1, 32'hF100_0000, 2, 1'b0, 4'b1000, 32'h0,        32'h0000_00F1);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0000_6000, 32'h0,        2'b01, 1'b0, 32'hFFFF_7FFE, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_7FFE);
    vecs[8]  = mk(1'b0, 1'b1, 32'h0000_7002, 32'h1234_ABCD, 2'b01, 1'b0, 32'h0,        3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    vecs[9]  = mk(1'b0, 1'b1, 32'h0000_7001, 32'h1234_ABCD, 2'b01, 1'b0, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    vecs[10] = mk(1'b1, 1'b0, 32'h0000_8000, 32'h0,        2'b11, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D);
    vecs[11] = mk(1'b0, 1'b1, 32'h0000_9004, 32'h0102_0304, 2'b10, 1'b0, 32'h0,        1, 1'b0, 4'b1111, 32'h0102_0304, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 32'h0000_A002, 32'h0,        2'b00, 1'b0, 32'h007F_0000, 0, 1'b0, 4'b0100, 32'h0,        32'h0000_007F);
    vecs[13] = mk(1'b0, 1'b1, 32'h0000_A000, 32'h1234_56CD, 2'b00, 1'b0, 32'h0,        0, 1'b0, 4'b0001, 32'hCDCD_CDCD, 32'h0);

    // Reset: a pending request must not stall or reach the bus
    nrst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    MEM_rd_en = 1'b1; MEM_wr_en = 1'b0; MEM_addr = 32'h0; MEM_wdata = 32'h0;
    MEM_size = 2'b10; MEM_unsigned = 1'b0;
    model_dout = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_dataout", MEM_dataout, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    idle_inputs();
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", 32'(mem_req), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // mem_ack while IDLE must be ignored
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_dataout", MEM_dataout, model_dout);

    // Inputs and acks presented during DONE must be ignored
    @(negedge clk);
    MEM_rd_en = 1'b1; MEM_addr = 32'h0000_B000; MEM_size = 2'b10; MEM_unsigned = 1'b0;
    @(posedge clk); #1; idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    MEM_rd_en = 1'b1; MEM_addr = 32'h0000_C000;
    #1;
    chk("done_ignores_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs(); mem_ack = 1'b0;
    chk("done_ignores_req", 32'(mem_req), 32'd0);
    chk("done_ignores_dataout", MEM_dataout, 32'h1111_2222);
    model_dout = 32'h1111_2222;

    // Reset in the middle of an access abandons it immediately
    @(negedge clk);
    MEM_rd_en = 1'b1; MEM_addr = 32'h0000_D000; MEM_size = 2'b10;
    @(posedge clk); #1; idle_inputs();
    chk("mid_req_before_rst", 32'(mem_req), 32'd1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_dataout", MEM_dataout, 32'h0);
    model_dout = 32'h0;
    @(negedge clk); nrst = 1'b1;
    run_vec(mk(1'b1, 1'b0, 32'h0000_E000, 32'h0, 2'b10, 1'b0, 32'h2468_ACE0, 1,
               1'b0, 4'b1111, 32'h0, 32'h2468_ACE0), 100);

    // A load that is never acknowledged
    begin
      int req_cycles;
      int low_cycles;
      int err_seen;
      @(negedge clk);
      MEM_rd_en = 1'b1; MEM_addr = 32'h0000_F000; MEM_size = 2'b10;
      @(posedge clk); #1; idle_inputs();
`ifdef MEM_ACCESS_TIMEOUT_EN
      req_cycles = 0;
      while (mem_req && req_cycles < 400) begin
        req_cycles++;
        @(posedge clk); #1;
      end
      chk("timeout_access_cycles", 32'(req_cycles), 32'd255);
      chk("timeout_err_pulse", 32'(timeout_err), 32'd1);
      chk("timeout_stall", 32'(stall), 32'd0);
      chk("timeout_dataout", MEM_dataout, 32'h0);
      model_dout = 32'h0;
      @(posedge clk); #1;
      chk("timeout_err_end", 32'(timeout_err), 32'd0);
`else
      low_cycles = 0; err_seen = 0; req_cycles = 0;
      for (int c = 0; c < 300; c++) begin
        if (!stall) low_cycles++;
        if (timeout_err) err_seen++;
        if (mem_req) req_cycles++;
        @(posedge clk); #1;
      end
      chk("hang_stall_low_cycles", 32'(low_cycles), 32'd0);
      chk("hang_req_cycles", 32'(req_cycles), 32'd300);
      chk("hang_timeout_err", 32'(err_seen), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      @(posedge clk); #1; mem_ack = 1'b0;
      model_dout = 32'h0BAD_F00D;
      chk("hang_done_stall", 32'(stall), 32'd0);
      chk("hang_done_dataout", MEM_dataout, model_dout);
`endif
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
